// File: rtl/mcp3202_pkg.sv
// Shared types, protocol constants and result-selection helpers for the
// MCP3202 responder.
package mcp3202_pkg;

    localparam int CMD_BITS = 3;
    localparam int DATA_W   = 12;

    localparam logic [DATA_W-1:0] DIFF_SAT_ZERO = '0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_CMD        = 3'd2,
        ST_NULL       = 3'd3,
        ST_DATA       = 3'd4,
        ST_TRAIL      = 3'd5
    } mcp_state_e;

    // Pseudo-differential reading: a negative difference clamps to zero,
    // which is what the real converter reports for IN+ below IN-.
    function automatic logic [DATA_W-1:0] sat_diff(
        input logic [DATA_W-1:0] pos,
        input logic [DATA_W-1:0] neg
    );
        return (pos > neg) ? (pos - neg) : DIFF_SAT_ZERO;
    endfunction

    function automatic logic [DATA_W-1:0] select_sample(
        input logic              sgl,
        input logic              odd,
        input logic [DATA_W-1:0] ch0,
        input logic [DATA_W-1:0] ch1
    );
        if (sgl) begin
            return odd ? ch1 : ch0;
        end
        return odd ? sat_diff(ch1, ch0) : sat_diff(ch0, ch1);
    endfunction

endpackage

// File: rtl/mcp3202_spi_responder_spi_pin_sync.sv
// Multi-flop synchronizer for one SPI pin with rise/fall strobes derived from
// the synchronized level; the reset level matches the pin's idle state.
module spi_pin_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/mcp3202_spi_responder.sv
// MCP3202 emulation: oversampled mode-0 SPI slave that decodes the command
// frame and returns a snapshotted 12-bit reading from the fabric channels.
module mcp3202_spi_responder #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] ch0_value,
    input  logic [DATA_W-1:0] ch1_value,
    output logic              done,
    output logic              done_chan,
    output logic              done_sgl,
    output logic [DATA_W-1:0] done_value,
    output logic              abort,
    output logic [15:0]       frame_count,
    output logic [2:0]        dbg_state
);

    import mcp3202_pkg::*;

    localparam logic [1:0] LAST_CMD = 2'(CMD_BITS - 1);
    localparam logic [3:0] MSB_IDX  = 4'(DATA_W - 1);
    localparam logic [3:0] TAIL_END = 4'(DATA_W);

    logic sck_lvl, sck_rise, sck_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_i   (spi_sck),
        .level_o (sck_lvl),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_i   (spi_cs_n),
        .level_o (cs_lvl),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_i   (spi_mosi),
        .level_o (mosi_lvl),
        .rise_o  (mosi_rise),
        .fall_o  (mosi_fall)
    );

    assign unused_sync = &{1'b0, sck_lvl, cs_lvl, mosi_rise, mosi_fall};

    mcp_state_e        state_q;
    logic [1:0]        cmd_idx_q;
    logic [3:0]        bit_idx_q;
    logic              b0_sent_q;
    logic              sgl_q;
    logic              odd_q;
    logic              msbf_q;
    logic [DATA_W-1:0] hold_q;
    logic              miso_q;
    logic              oe_q;
    logic              done_q;
    logic              abort_q;
    logic              done_chan_q;
    logic              done_sgl_q;
    logic [DATA_W-1:0] done_value_q;
    logic [15:0]       frame_count_q;
    logic [15:0]       frame_count_d;

    assign frame_count_d = frame_count_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cmd_idx_q     <= '0;
            bit_idx_q     <= '0;
            b0_sent_q     <= 1'b0;
            sgl_q         <= 1'b0;
            odd_q         <= 1'b0;
            msbf_q        <= 1'b0;
            hold_q        <= '0;
            miso_q        <= 1'b0;
            oe_q          <= 1'b0;
            done_q        <= 1'b0;
            abort_q       <= 1'b0;
            done_chan_q   <= 1'b0;
            done_sgl_q    <= 1'b0;
            done_value_q  <= '0;
            frame_count_q <= '0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            // CS release wins over any SCK edge seen in the same cycle.
            if (state_q != ST_IDLE && cs_rise) begin
                state_q <= ST_IDLE;
                oe_q    <= 1'b0;
                miso_q  <= 1'b0;
                abort_q <= (state_q != ST_TRAIL);
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state_q <= ST_WAIT_START;
                            oe_q    <= 1'b1;
                            miso_q  <= 1'b0;
                        end
                    end
                    ST_WAIT_START: begin
                        if (sck_rise && mosi_lvl) begin
                            state_q   <= ST_CMD;
                            cmd_idx_q <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            cmd_idx_q <= cmd_idx_q + 2'd1;
                            if (cmd_idx_q == 2'd0) begin
                                sgl_q <= mosi_lvl;
                            end else if (cmd_idx_q != LAST_CMD) begin
                                odd_q  <= mosi_lvl;
                                hold_q <= select_sample(sgl_q, mosi_lvl, ch0_value, ch1_value);
                            end else begin
                                msbf_q  <= mosi_lvl;
                                state_q <= ST_NULL;
                            end
                        end
                    end
                    ST_NULL: begin
                        if (sck_fall) begin
                            miso_q    <= 1'b0;
                            state_q   <= ST_DATA;
                            bit_idx_q <= MSB_IDX;
                            b0_sent_q <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        if (sck_fall && !b0_sent_q) begin
                            miso_q <= hold_q[bit_idx_q];
                            if (bit_idx_q == 4'd0) begin
                                b0_sent_q <= 1'b1;
                            end else begin
                                bit_idx_q <= bit_idx_q - 4'd1;
                            end
                        end else if (sck_rise && b0_sent_q) begin
                            done_q        <= 1'b1;
                            done_chan_q   <= odd_q;
                            done_sgl_q    <= sgl_q;
                            done_value_q  <= hold_q;
                            frame_count_q <= frame_count_d;
                            state_q       <= ST_TRAIL;
                            bit_idx_q     <= 4'd1;
                        end
                    end
                    ST_TRAIL: begin
                        // LSB-first replay reuses B0 already sent, so it starts at B1.
                        if (sck_fall) begin
                            if (!msbf_q && bit_idx_q < TAIL_END) begin
                                miso_q    <= hold_q[bit_idx_q];
                                bit_idx_q <= bit_idx_q + 4'd1;
                            end else begin
                                miso_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        oe_q    <= 1'b0;
                        miso_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign done        = done_q;
    assign done_chan   = done_chan_q;
    assign done_sgl    = done_sgl_q;
    assign done_value  = done_value_q;
    assign abort       = abort_q;
    assign frame_count = frame_count_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/mcp3202_spi_responder.md
# mcp3202_spi_responder

Synthesizable SPI slave that emulates an MCP3202 12-bit, 2-channel ADC on a single system clock. It answers the MCP3202 command frame (start, SGL/DIFF, ODD/SIGN, MSBF) with a null bit and 12 data bits taken from two fabric-side channel registers. This lets the existing SPI ADC master logic be exercised against simulated sensor values (accelerator pedal on CH0, light sensor on CH1) without the physical chip. It sits at the board-level SPI pins, or in loopback with the master, and runs entirely in the `clk` domain by oversampling SCK.

## Interface
- `DATA_W`, default 12: conversion width. Fixed by the protocol, so only 12 is supported.
- `SYNC_STAGES`, default 2: synchronizer depth on `spi_sck`, `spi_cs_n` and `spi_mosi`. Must be 2 or more.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `spi_sck` in 1: SPI clock from the master, mode 0,0, asynchronous to `clk`.
- `spi_cs_n` in 1: chip select, active low.
- `spi_mosi` in 1: command bits from the master.
- `spi_miso` out 1: response data.
- `spi_miso_oe` out 1: tri-state enable for the top-level pad.
- `ch0_value` in 12: CH0 sample. Must be stable in the `clk` domain.
- `ch1_value` in 12: CH1 sample.
- `done` out 1: one-cycle pulse when a frame completes through B0.
- `done_chan` out 1: ODD/SIGN bit of the completed frame.
- `done_sgl` out 1: SGL/DIFF bit of the completed frame.
- `done_value` out 12: value returned by the completed frame.
- `abort` out 1: one-cycle pulse when CS rises before frame completion.
- `frame_count` out 16: count of completed frames. Wraps from 0xFFFF to 0.

## Operation
- **Input conditioning.** `spi_sck`, `spi_cs_n` and `spi_mosi` are synchronized, then edge-detected. This produces `sck_rise`, `sck_fall`, `cs_fall` and `cs_rise` strobes.
- **States:** IDLE, WAIT_START, CMD, NULL, DATA, TRAIL.
- **IDLE.**
  - `spi_miso_oe`=0 and `spi_miso`=0.
  - `cs_fall` moves to WAIT_START and sets `spi_miso_oe`=1.
- **WAIT_START.**
  - On `sck_rise` with mosi=0: the bit is ignored (leading zeros are allowed).
  - On `sck_rise` with mosi=1: move to CMD with cmd_idx=0.
- **CMD.**
  - Rising edges 1, 2 and 3 capture SGL, ODD and MSBF.
  - On the ODD capture, the result is snapshotted into a 12-bit holding register:
    - SGL=1: ODD selects `ch1_value` or `ch0_value`.
    - SGL=0, ODD=0: saturating `ch0_value - ch1_value`, clamped to 0 when negative.
    - SGL=0, ODD=1: saturating `ch1_value - ch0_value`.
  - Channel inputs changing after the snapshot do not affect the frame.
- **NULL.** The `sck_fall` after the MSBF capture drives `spi_miso`=0 (the null bit).
- **DATA.**
  - The next 12 `sck_fall` edges drive B11..B0, MSB first.
  - The `sck_rise` after B0 is driven completes the frame. On that rise:
    - `done` pulses;
    - `done_*` load;
    - `frame_count` increments;
    - the state moves to TRAIL.
- **TRAIL.**
  - If MSBF=0, subsequent falls drive B1..B11, LSB first.
  - Then, or when MSBF=1, the block drives 0 until CS rises.
- **CS rise in any non-IDLE state.**
  - Move to IDLE and set `spi_miso_oe`=0 and `spi_miso`=0.
  - `abort` pulses if `done` has not yet fired for this frame.
  - A CS rise in TRAIL is not an abort.
- **CS fall while not in IDLE** cannot occur, because CS rise is always seen first. A glitch shorter than the sync depth is filtered.
- **Simultaneous events.** When `cs_rise` and an SCK edge strobe arrive in the same cycle, `cs_rise` wins.

## Timing
- **Reset values.** All outputs 0, except that the synchronizer flops reset to idle levels: cs_n=1, sck=0, mosi=0. State is IDLE.
- **Reset mid-frame.** Immediately releases MISO (`spi_miso_oe`=0). No `abort` pulse is emitted.
- **MISO latency.** `spi_miso` updates `SYNC_STAGES`+1 `clk` cycles after the physical SCK falling edge.
- **Required SCK rate.** SCK half-period must be at least `SYNC_STAGES`+2 `clk` cycles. The codebase master uses 25, which satisfies this.
- **Status latency.** `done` and `abort` assert `SYNC_STAGES`+1 cycles after the corresponding pin edge.
- **Status hold.** `done_*` outputs hold until the next `done`.

## Structure
- Package `mcp3202_pkg` contains:
  - state enum;
  - `CMD_BITS`=3 (after start);
  - `DATA_W`=12;
  - `DIFF_SAT_ZERO` constant;
  - a function for the saturating difference.
- Sub-module `spi_pin_sync` (SYNC_STAGES flops plus edge detect, with a reset-level parameter) is instantiated three times.

## Test plan
- **CH0 single-ended read.** `ch0_value`=0xA5C, frame with start/SGL=1/ODD=0/MSBF=1, SCK half-period 25 clk → master samples null 0 then 0xA5C; `done`=1, `done_chan`=0, `done_value`=0xA5C, `frame_count`=1.
- **CH1 read with leading zeros and mid-frame change.** `ch1_value`=0x0FF, 3 leading zero bits before start; `ch1_value` changes to 0x123 after the ODD capture → returned value is 0x0FF.
- **Differential saturation.**
  - SGL=0, ODD=0, `ch0_value`=0x100, `ch1_value`=0x180 → returns 0x000.
  - Same inputs with ODD=1 → returns 0x080.
- **LSB-first tail.** MSBF=0 with `ch0_value`=0x801, 28 SCKs total → MISO stream is B11..B0 then B1..B11, trailing 0s.
- **Abort and wrap.**
  - CS rises after 8 data bits → `abort`=1, `done`=0, `spi_miso_oe`=0 within `SYNC_STAGES`+1 cycles.
  - Force `frame_count`=0xFFFF and complete one frame → count becomes 0.
- **Reset mid-frame.** Assert `rst_n` low during DATA → all outputs 0 and no `abort`; the next frame after release completes normally.
